// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep chunked ripple-carry add/sub pipeline with saturation.
// Valid/ready on both sides; backpressure ripples combinationally to o_ready.
`default_nettype none

module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic             carry_flag
);

  localparam int CH = WIDTH / STAGES;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_vin;

  // Stage k may advance iff any stage from k to the output is empty, or the sink takes the result.
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_hs
      assign w_adv[k] = i_ready | ~(&valid_q[STAGES-1:k]);
      if (k == 0) begin : g_vin0
        assign w_vin[k] = i_valid;
      end else begin : g_vinn
        assign w_vin[k] = valid_q[k-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~w_adv) | (w_vin & w_adv);
    end
  end

  assign o_ready = w_adv[0];
  assign o_valid = valid_q[STAGES-1];

  // Intermediate stages: add one chunk, keep only the operand chunks still to be consumed.
  generate
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
      localparam int RW = WIDTH - (k + 1) * CH;
      localparam int SW = (k + 1) * CH;

      logic [RW+CH-1:0] w_a;
      logic [RW+CH-1:0] w_b;
      logic             w_cin;
      logic             w_sat;
      logic [CH-1:0]    w_sum;
      logic             w_c;
      logic [SW-1:0]    w_s;

      logic [RW-1:0]    a_q;
      logic [RW-1:0]    b_q;
      logic [SW-1:0]    s_q;
      logic             c_q;
      logic             sat_q;

      if (k == 0) begin : g_first
        assign w_a   = i_1;
        assign w_b   = i_2 ^ {WIDTH{i_op[0]}};
        assign w_cin = i_op[0];
        assign w_sat = i_op[1];
        assign w_s   = w_sum;
      end else begin : g_next
        assign w_a   = g_stage[k-1].a_q;
        assign w_b   = g_stage[k-1].b_q;
        assign w_cin = g_stage[k-1].c_q;
        assign w_sat = g_stage[k-1].sat_q;
        assign w_s   = {w_sum, g_stage[k-1].s_q};
      end

      assign {w_c, w_sum} = {1'b0, w_a[CH-1:0]} + {1'b0, w_b[CH-1:0]} + {{CH{1'b0}}, w_cin};

      always_ff @(posedge clk) begin
        if (w_adv[k] && w_vin[k]) begin
          a_q   <= w_a[RW+CH-1:CH];
          b_q   <= w_b[RW+CH-1:CH];
          s_q   <= w_s;
          c_q   <= w_c;
          sat_q <= w_sat;
        end
      end
    end
  endgenerate

  logic [CH-1:0]    w_la;
  logic [CH-1:0]    w_lb;
  logic [CH-1:0]    w_top;
  logic             w_lcin;
  logic             w_lsat;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;

  generate
    if (STAGES == 1) begin : g_single
      assign w_la   = i_1;
      assign w_lb   = i_2 ^ {WIDTH{i_op[0]}};
      assign w_lcin = i_op[0];
      assign w_lsat = i_op[1];
      assign w_raw  = w_top;
    end else begin : g_multi
      assign w_la   = g_stage[STAGES-2].a_q;
      assign w_lb   = g_stage[STAGES-2].b_q;
      assign w_lcin = g_stage[STAGES-2].c_q;
      assign w_lsat = g_stage[STAGES-2].sat_q;
      assign w_raw  = {w_top, g_stage[STAGES-2].s_q};
    end
  endgenerate

  assign {w_carry, w_top} = {1'b0, w_la} + {1'b0, w_lb} + {{CH{1'b0}}, w_lcin};

  // w_la/w_lb hold the top chunk, so bit CH-1 is the operand sign.
  assign w_ovf = (w_la[CH-1] == w_lb[CH-1]) && (w_raw[WIDTH-1] != w_la[CH-1]);
  assign w_res = (w_lsat && w_ovf) ? {w_la[CH-1], {(WIDTH-1){~w_la[CH-1]}}} : w_raw;

  logic [WIDTH-1:0] o_q;
  logic             zero_q;
  logic             ovf_q;
  logic             carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (w_adv[STAGES-1] && w_vin[STAGES-1]) begin
      o_q     <= w_res;
      zero_q  <= (w_res == '0);
      ovf_q   <= w_ovf;
      carry_q <= w_carry;
    end
  end

  assign o             = o_q;
  assign zero_flag     = zero_q;
  assign overflow_flag = ovf_q;
  assign carry_flag    = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: scoreboard bench for pipe_addsub (WIDTH=32, STAGES=4).
// Expected results come from signed integer arithmetic on the operands.
`default_nettype none

module tb_pipe_addsub;

  localparam int W = 32;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b1;
  logic [W-1:0]  i_1 = '0;
  logic [W-1:0]  i_2 = '0;
  logic [1:0]    i_op = 2'b00;
  logic          o_ready;
  logic          o_valid;
  logic [W-1:0]  o;
  logic          zero_flag;
  logic          overflow_flag;
  logic          carry_flag;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_1(i_1), .i_2(i_2), .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready),
    .o(o), .zero_flag(zero_flag), .overflow_flag(overflow_flag), .carry_flag(carry_flag)
  );

  typedef logic [W+2:0] exp_t;  // {o, zero, overflow, carry}
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    longint      sa, sb, ideal;
    logic        ovf, cy;
    logic [31:0] r;
    logic [63:0] ua, ub;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ideal = op[0] ? sa - sb : sa + sb;
    ovf   = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
    r     = ideal[31:0];
    ua    = {32'd0, a};
    ub    = {32'd0, b};
    cy    = op[0] ? (a >= b) : ((ua + ub) > 64'hFFFF_FFFF);
    if (op[1] && ovf) r = (ideal > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {r, (r == 32'd0), ovf, cy};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops and compares on every output transfer, and checks hold during stalls.
  logic stalled_prev = 1'b0;
  exp_t held;
  exp_t exp_e;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && o_valid)
        chk("stall_hold", {o, zero_flag, overflow_flag, carry_flag}, held);
      stalled_prev = o_valid && !i_ready;
      held = {o, zero_flag, overflow_flag, carry_flag};
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {63'd0, o_valid}, 64'd0);
        end else begin
          exp_e = q.pop_front();
          chk("result", {o, zero_flag, overflow_flag, carry_flag}, exp_e);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input logic rdy, output logic acc);
    @(negedge clk);
    i_valid = v;
    i_1     = a;
    i_2     = b;
    i_op    = op;
    i_ready = rdy;
    #1;
    acc = v && o_ready;
    if (acc) q.push_back(model(a, b, op));
  endtask

  task automatic drain();
    logic acc;
    int   n = 0;
    while (q.size() != 0 && n < 60) begin
      cyc(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
      n++;
    end
    chk("drain_empty", q.size(), 64'd0);
  endtask

  // Issues one operand into an empty pipeline and checks o_valid rises exactly S cycles later.
  task automatic lat_check(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic acc;
    cyc(1'b1, a, b, op, 1'b1, acc);
    chk("accept", acc, 64'd1);
    for (int k = 1; k <= S; k++) begin
      cyc(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
      chk("latency", o_valid, (k == S));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic saw;
    int   sent;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {o_valid, o, zero_flag, overflow_flag, carry_flag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", o_ready, 64'd1);

    lat_check(32'd15, 32'd39, 2'b00);
    drain();

    cyc(1'b1, 32'd15,          32'd39, 2'b01, 1'b1, acc);
    cyc(1'b1, 32'd5,           32'd5,  2'b01, 1'b1, acc);
    cyc(1'b1, 32'h7FFF_FFFF,   32'd1,  2'b00, 1'b1, acc);
    cyc(1'b1, 32'h7FFF_FFFF,   32'd1,  2'b10, 1'b1, acc);
    cyc(1'b1, 32'h8000_0000,   32'd1,  2'b11, 1'b1, acc);
    cyc(1'b1, 32'h8000_0000,   32'd1,  2'b01, 1'b1, acc);
    cyc(1'b1, 32'hFFFF_FFFF,   32'd1,  2'b00, 1'b1, acc);
    cyc(1'b1, 32'h0000_0000,   32'h8000_0000, 2'b11, 1'b1, acc);
    drain();

    // Eight back-to-back operands with the sink stalled for three cycles.
    saw  = 1'b0;
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(sent < 8, pick(), pick(), 2'($urandom_range(3)), !(c >= 3 && c <= 5), acc);
      if (acc) sent++;
      if (o_valid && !i_ready && !o_ready) saw = 1'b1;
    end
    chk("sent_all", sent, 64'd8);
    chk("o_ready_low_when_full", saw, 64'd1);
    drain();

    repeat (400) begin
      cyc(($urandom % 10) < 7, pick(), pick(), 2'($urandom_range(3)), ($urandom % 4) != 0, acc);
    end
    drain();

    // Three entries in flight, then a one-cycle reset pulse.
    repeat (3) cyc(1'b1, pick(), pick(), 2'($urandom_range(3)), 1'b1, acc);
    @(negedge clk);
    rst     = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("reset_flush", {o_valid, o, zero_flag, overflow_flag, carry_flag}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", o_ready, 64'd1);
    lat_check(32'd100, 32'd58, 2'b01);
    drain();
    repeat (8) cyc(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
    chk("final_empty", q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
